// File: rtl/inst_rom_arbiter_if.sv
// Bus bundle between the two ROM requesters (fetch, debug), the shared instruction ROM and the arbiter.
// master = requester/ROM side, slave = arbiter side.
interface inst_rom_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              f_err;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_inst;

    modport master (
        output f_req, f_addr, d_req, d_addr, rom_inst,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  rom_ce, rom_addr
    );

    modport slave (
        input  f_req, f_addr, d_req, d_addr, rom_inst,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output rom_ce, rom_addr
    );
endinterface

// File: rtl/inst_rom_arbiter.sv
// Shares one combinational instruction ROM between the fetch port (index 0) and the debug port (index 1).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority with a debug starvation escape.
module inst_rom_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    inst_rom_arbiter_if.slave bus
);
    logic [1:0]        req;
    logic [ADDR_W-1:0] addr [2];
    logic [1:0]        gnt;
    logic              gnt_any;
    logic              gnt_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic              aligned;
    logic              last_gnt_reg;

    logic              resp_valid_reg;
    logic              resp_owner_reg;
    logic              resp_err_reg;
    logic [DATA_W-1:0] rdata_reg [2];
    logic [1:0]        rvalid;
    logic [1:0]        rerr;

    assign req     = {bus.d_req, bus.f_req};
    assign addr[0] = bus.f_addr;
    assign addr[1] = bus.d_addr;

`ifdef ARB_ROUND_ROBIN_EN
    // Tie goes to the port that did not win last; rst low suppresses every grant.
    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            if (req == 2'b11) begin
                gnt = last_gnt_reg ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_reg;
    logic [3:0] starve_cnt_next;

    // Fetch has priority unless debug has lost STARVE_MAX cycles in a row.
    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            if (req[1] && (!req[0] || starve_cnt_reg == STARVE_LIM)) begin
                gnt = 2'b10;
            end else if (req[0]) begin
                gnt = 2'b01;
            end
        end
    end

    always_comb begin
        starve_cnt_next = 4'd0;
        if (req[1] && !gnt[1]) begin
            starve_cnt_next = (starve_cnt_reg == 4'hF) ? 4'hF : starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_reg <= 4'd0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`endif

    assign gnt_any  = |gnt;
    assign gnt_idx  = gnt[1];
    assign sel_addr = addr[gnt_idx];
    assign aligned  = (sel_addr[1:0] == 2'b00);

    assign bus.f_gnt    = gnt[0];
    assign bus.d_gnt    = gnt[1];
    assign bus.rom_ce   = gnt_any && aligned;
    assign bus.rom_addr = gnt_any ? sel_addr : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_reg   <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_owner_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
        end else begin
            resp_valid_reg <= gnt_any;
            if (gnt_any) begin
                last_gnt_reg   <= gnt_idx;
                resp_owner_reg <= gnt_idx;
                resp_err_reg   <= !aligned;
            end
        end
    end

    // Each port keeps its own data register so the non-owner's rdata stays put.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdata_reg[gi] <= '0;
                end else if (gnt[gi]) begin
                    rdata_reg[gi] <= aligned ? bus.rom_inst : '0;
                end
            end

            assign rvalid[gi] = resp_valid_reg && (resp_owner_reg == 1'(gi));
            assign rerr[gi]   = rvalid[gi] && resp_err_reg;
        end
    endgenerate

    assign bus.f_rvalid = rvalid[0];
    assign bus.f_err    = rerr[0];
    assign bus.f_rdata  = rdata_reg[0];
    assign bus.d_rvalid = rvalid[1];
    assign bus.d_err    = rerr[1];
    assign bus.d_rdata  = rdata_reg[1];

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter: a cycle-level model (priority rules + response queue) checked every
// negedge, plus literal expectations for the key scenarios. Honours ARB_ROUND_ROBIN_EN like the design.
module tb_inst_rom_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    typedef struct {
        logic        owner;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    inst_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    inst_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {8'hC0, 18'h0, a[7:2]};
    endfunction

    // ROM contents: word i holds 0xC000_0000 + i; garbage whenever chip-enable is low.
    assign bus.rom_inst = bus.rom_ce ? rom_word(bus.rom_addr) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: evaluated on every falling edge, when inputs and DUT outputs are stable.
    int          m_wait = 0;
    logic        m_last = 1'b1;
    resp_t       pend[$];
    logic [31:0] m_frd = '0;
    logic [31:0] m_drd = '0;
    int          cyc = 0;

    always @(negedge clk) begin
        logic        ef, ed, hv;
        logic [31:0] wa;
        resp_t       cur;
        resp_t       nr;
        cyc++;
        if (!rst) begin
            m_wait = 0;
            m_last = 1'b1;
            pend.delete();
            m_frd = '0;
            m_drd = '0;
            check("rst_f_gnt", 32'(bus.f_gnt), 0);
            check("rst_d_gnt", 32'(bus.d_gnt), 0);
            check("rst_rom_ce", 32'(bus.rom_ce), 0);
            check("rst_rom_addr", bus.rom_addr, 0);
            check("rst_f_rvalid", 32'(bus.f_rvalid), 0);
            check("rst_d_rvalid", 32'(bus.d_rvalid), 0);
            check("rst_f_err", 32'(bus.f_err), 0);
            check("rst_d_err", 32'(bus.d_err), 0);
            check("rst_f_rdata", bus.f_rdata, 0);
            check("rst_d_rdata", bus.d_rdata, 0);
            $display("cyc %0d reset", cyc);
        end else begin
            ef = 1'b0;
            ed = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            if (bus.f_req && bus.d_req) begin
                if (m_last) ef = 1'b1;
                else        ed = 1'b1;
            end else begin
                ef = bus.f_req;
                ed = bus.d_req;
            end
`else
            if (bus.d_req && (!bus.f_req || m_wait == SMAX)) ed = 1'b1;
            else if (bus.f_req)                              ef = 1'b1;
`endif
            wa = ed ? bus.d_addr : (ef ? bus.f_addr : 32'h0);
            check("f_gnt", 32'(bus.f_gnt), 32'(ef));
            check("d_gnt", 32'(bus.d_gnt), 32'(ed));
            check("rom_ce", 32'(bus.rom_ce), 32'((ef || ed) && wa[1:0] == 2'b00));
            check("rom_addr", bus.rom_addr, wa);

            hv = (pend.size() > 0);
            cur = '{owner: 1'b0, err: 1'b0, data: 32'h0};
            if (hv) cur = pend.pop_front();
            if (hv && !cur.owner) m_frd = cur.data;
            if (hv &&  cur.owner) m_drd = cur.data;
            check("f_rvalid", 32'(bus.f_rvalid), 32'(hv && !cur.owner));
            check("d_rvalid", 32'(bus.d_rvalid), 32'(hv && cur.owner));
            check("f_err", 32'(bus.f_err), 32'(hv && !cur.owner && cur.err));
            check("d_err", 32'(bus.d_err), 32'(hv && cur.owner && cur.err));
            check("f_rdata", bus.f_rdata, m_frd);
            check("d_rdata", bus.d_rdata, m_drd);

            if (ef || ed) begin
                nr.owner = ed;
                nr.err   = (wa[1:0] != 2'b00);
                nr.data  = (wa[1:0] == 2'b00) ? rom_word(wa) : 32'h0;
                pend.push_back(nr);
            end
            $display("cyc %0d f_req=%0b d_req=%0b grant=%s addr=%h f_rv=%0b d_rv=%0b",
                     cyc, bus.f_req, bus.d_req, ed ? "D" : (ef ? "F" : "-"), wa,
                     bus.f_rvalid, bus.d_rvalid);

            if (bus.d_req && !ed) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
            else                  m_wait = 0;
            if (ef || ed) m_last = ed;
        end
    end

    logic [6:0] dpat;
    logic [6:0] dpat_exp;
    logic [6:0] drv_exp;
    logic [6:0] drv_pat;

    initial begin
        bus.f_req  = 1'b0;
        bus.f_addr = '0;
        bus.d_req  = 1'b0;
        bus.d_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        // Single aligned fetch
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h0000_0008;
        @(negedge clk);
        check("single_f_gnt", 32'(bus.f_gnt), 1);
        check("single_rom_ce", 32'(bus.rom_ce), 1);
        check("single_rom_addr", bus.rom_addr, 32'h8);
        step();
        bus.f_req = 1'b0;
        @(negedge clk);
        check("single_f_rvalid", 32'(bus.f_rvalid), 1);
        check("single_f_rdata", bus.f_rdata, 32'hC000_0002);
        check("single_f_err", 32'(bus.f_err), 0);
        step();

        // Misaligned debug read
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0006;
        @(negedge clk);
        check("mis_d_gnt", 32'(bus.d_gnt), 1);
        check("mis_rom_ce", 32'(bus.rom_ce), 0);
        step();
        bus.d_req = 1'b0;
        @(negedge clk);
        check("mis_d_rvalid", 32'(bus.d_rvalid), 1);
        check("mis_d_err", 32'(bus.d_err), 1);
        check("mis_d_rdata", bus.d_rdata, 0);
        step();

        // Contention with both requests held
`ifdef ARB_ROUND_ROBIN_EN
        dpat_exp = 7'b0101010;
        drv_exp  = 7'b1010100;
`else
        dpat_exp = 7'b0010000;
        drv_exp  = 7'b0100000;
`endif
        bus.f_req  = 1'b1;
        bus.d_req  = 1'b1;
        bus.f_addr = 32'h10;
        bus.d_addr = 32'h20;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            dpat[i]    = bus.d_gnt;
            drv_pat[i] = bus.d_rvalid;
            step();
        end
        check("contend_d_gnt_pattern", 32'(dpat), 32'(dpat_exp));
        check("contend_d_rvalid_pattern", 32'(drv_pat), 32'(drv_exp));
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        step();

        // Streaming fetch, one word per cycle
        bus.f_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.f_addr = 32'(i * 4);
            @(negedge clk);
            if (i > 0) begin
                check("stream_f_rvalid", 32'(bus.f_rvalid), 1);
                check("stream_f_rdata", bus.f_rdata, 32'hC000_0000 + 32'(i - 1));
            end
            step();
        end
        bus.f_req = 1'b0;
        @(negedge clk);
        check("stream_last_f_rvalid", 32'(bus.f_rvalid), 1);
        check("stream_last_f_rdata", bus.f_rdata, 32'hC000_0003);
        step();

        // Reset asserted while a response is pending
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h0000_000C;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rmid_f_rvalid", 32'(bus.f_rvalid), 0);
        check("rmid_f_rdata", bus.f_rdata, 0);
        check("rmid_f_gnt", 32'(bus.f_gnt), 0);
        check("rmid_rom_ce", 32'(bus.rom_ce), 0);
        step();
        bus.f_req = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rmid_after_f_rvalid", 32'(bus.f_rvalid), 0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
